serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes Diff = A - B (mod 2^WIDTH) and a Borrow flag. It processes one bit per clock, LSB first, using a half-subtractor pair and a registered borrow flip-flop. It is the sequential, subtract-direction counterpart to the combinational adder cells in the arithmetic library. It serves area-constrained datapaths that can accept WIDTH-cycle latency.

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B (mod 2^WIDTH), LSB first, one bit per clock.
// Borrow is set when A < B; Done pulses for one cycle when Diff and Borrow update.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, diff_q, diff_d;
   logic             bin_q, bin_d, borrow_q, borrow_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_bit, bout;
   logic [WIDTH-1:0] p_shift;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      p_d      = p_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;

      d_bit   = a_q[0] ^ b_q[0] ^ bin_q;
      bout    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
      // New difference bit enters at the MSB so the result lands LSB-aligned after WIDTH shifts.
      p_shift = p_q >> 1;
      p_shift[WIDTH-1] = d_bit;

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               a_d     = A;
               b_d     = B;
               bin_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            p_d   = p_shift;
            bin_d = bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               diff_d   = p_shift;
               borrow_d = bout;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         p_q      <= '0;
         bin_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         p_q      <= p_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Diff   = diff_q;
   assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: instance 0 at WIDTH=8, instance 1 at WIDTH=1.
// Expected results are queued at each modelled accepting edge and checked when Done is due.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] start_s;
   logic [7:0] a_s [2];
   logic [7:0] b_s [2];
   logic [1:0] busy_s, done_s, borrow_s;
   logic [7:0] diff0;
   logic [0:0] diff1;

   typedef struct {
      logic [7:0] diff;
      logic       borrow;
      int         due;
   } exp_t;

   exp_t       sb [2][$];
   int         rem [2];
   int         n_acc [2];
   int         cyc;
   int         n_chk;
   int         n_fail;
   logic [7:0] m_diff [2];
   logic       m_borrow [2];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .Start(start_s[0]), .A(a_s[0]), .B(b_s[0]),
      .Busy(busy_s[0]), .Done(done_s[0]), .Diff(diff0), .Borrow(borrow_s[0])
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .Start(start_s[1]), .A(a_s[1][0:0]), .B(b_s[1][0:0]),
      .Busy(busy_s[1]), .Done(done_s[1]), .Diff(diff1), .Borrow(borrow_s[1])
   );

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 1;
   endfunction

   function automatic logic [7:0] msk(input int i);
      return (i == 0) ? 8'hFF : 8'h01;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: acceptance only when the modelled operation counter is idle.
   always @(posedge clk or negedge rst_n) begin : model
      exp_t       e;
      logic [7:0] am, bm;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            sb[i].delete();
         end
      end else begin
         cyc = cyc + 1;
         for (int i = 0; i < 2; i++) begin
            if (rem[i] == 0 && start_s[i]) begin
               am       = a_s[i] & msk(i);
               bm       = b_s[i] & msk(i);
               e.diff   = (am - bm) & msk(i);
               e.borrow = (am < bm);
               e.due    = cyc + wid(i);
               sb[i].push_back(e);
               rem[i]   = wid(i);
               n_acc[i]++;
            end else if (rem[i] > 0) begin
               rem[i]--;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [7:0] d;
      logic       exp_done;
      for (int i = 0; i < 2; i++) begin
         d = (i == 0) ? diff0 : {7'd0, diff1};
         if (!rst_n) begin
            m_diff[i]   = 8'd0;
            m_borrow[i] = 1'b0;
         end
         exp_done = (sb[i].size() > 0) && (sb[i][0].due == cyc);
         check($sformatf("busy%0d", i), busy_s[i], rem[i] != 0);
         if (done_s[i] || exp_done)
            check($sformatf("done%0d", i), done_s[i], exp_done);
         if (exp_done) begin
            e           = sb[i].pop_front();
            m_diff[i]   = e.diff;
            m_borrow[i] = e.borrow;
         end
         check($sformatf("diff%0d", i), d, m_diff[i]);
         check($sformatf("borrow%0d", i), borrow_s[i], m_borrow[i]);
      end
   end

   task automatic op(input int i, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start_s[i] = 1'b1;
      a_s[i]     = a;
      b_s[i]     = b;
      @(negedge clk);
      start_s[i] = 1'b0;
      a_s[i]     = 8'($urandom);
      b_s[i]     = 8'($urandom);
   endtask

   task automatic wait_idle(input int i, input int budget);
      int n = 0;
      while ((rem[i] != 0 || sb[i].size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      check($sformatf("idle_timeout%0d", i), sb[i].size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int base0, base1, n;
      cyc = 0; n_chk = 0; n_fail = 0;
      n_acc[0] = 0; n_acc[1] = 0;
      rst_n = 1'b0;
      start_s = 2'b00;
      for (int i = 0; i < 2; i++) begin
         a_s[i] = 8'd0;
         b_s[i] = 8'd0;
      end
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy_s[0], 1'b0);
      check("rst_done", done_s[0], 1'b0);
      check("rst_diff", diff0, 8'h00);
      check("rst_borrow", borrow_s[0], 1'b0);
      #1 rst_n = 1'b1;

      op(0, 8'h5A, 8'h3C); wait_idle(0, 40);
      check("t1_diff", diff0, 8'h1E); check("t1_borrow", borrow_s[0], 1'b0);
      op(0, 8'h00, 8'h01); wait_idle(0, 40);
      check("t2a_diff", diff0, 8'hFF); check("t2a_borrow", borrow_s[0], 1'b1);
      op(0, 8'hFF, 8'hFF); wait_idle(0, 40);
      check("t2b_diff", diff0, 8'h00); check("t2b_borrow", borrow_s[0], 1'b0);
      op(0, 8'h80, 8'h7F); wait_idle(0, 40);
      check("t2c_diff", diff0, 8'h01); check("t2c_borrow", borrow_s[0], 1'b0);

      // Second request during RUN must be ignored.
      op(0, 8'd10, 8'd3);
      repeat (2) @(negedge clk);
      op(0, 8'd0, 8'd200);
      wait_idle(0, 40);
      check("t4_diff", diff0, 8'h07); check("t4_borrow", borrow_s[0], 1'b0);

      // Reset mid-operation.
      op(0, 8'hC3, 8'h21);
      repeat (4) @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_busy", busy_s[0], 1'b0);
      check("t5_done", done_s[0], 1'b0);
      check("t5_diff", diff0, 8'h00);
      check("t5_borrow", borrow_s[0], 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      op(0, 8'h10, 8'h20); wait_idle(0, 40);
      check("t5_fresh_diff", diff0, 8'hF0); check("t5_fresh_borrow", borrow_s[0], 1'b1);

      op(1, 8'd0, 8'd1); wait_idle(1, 10);
      check("w1_diff", diff1, 1'b1); check("w1_borrow", borrow_s[1], 1'b1);
      op(1, 8'd1, 8'd0); wait_idle(1, 10);
      check("w1b_diff", diff1, 1'b1); check("w1b_borrow", borrow_s[1], 1'b0);

      // Start held high with operands changing every cycle on both instances.
      base0 = n_acc[0];
      base1 = n_acc[1];
      n = 0;
      start_s = 2'b11;
      while ((n_acc[0] - base0 < 1000 || n_acc[1] - base1 < 1000) && n < 12000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            a_s[i] = 8'($urandom);
            b_s[i] = 8'($urandom);
         end
         n++;
      end
      start_s = 2'b00;
      check("rand_acc0", n_acc[0] - base0 >= 1000, 1'b1);
      check("rand_acc1", n_acc[1] - base1 >= 1000, 1'b1);
      wait_idle(0, 40);
      wait_idle(1, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
